// File: rtl/mr_pkg.sv
// rtl/mr_pkg.sv - shared types and constants for the mr memory arbiter slice
package mr_pkg;

    localparam int XLEN  = 32;
    localparam int SEL_W = XLEN / 8;

    localparam logic ARB_M_IF = 1'b0;
    localparam logic ARB_M_LS = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN_IF,
        ARB_OWN_LS
    } arb_state_t;

endpackage

// File: rtl/mr_out_cnt.sv
// rtl/mr_out_cnt.sv - saturating up/down counter of outstanding bus requests
module mr_out_cnt #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         empty
);

    assign full  = (cnt == W'(MAX));
    assign empty = (cnt == '0);

    // A request and a response in the same cycle cancel; a spurious response at zero is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mr_mem_arb.sv
// rtl/mr_mem_arb.sv - IF/LS to single memory port arbiter, cyc-to-cyc grants
// Define MR_ARB_RR_EN for round-robin tie breaking instead of fixed LS priority.
module mr_mem_arb
    import mr_pkg::*;
#(
    parameter int  MAX_OUT = 2,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_cyc,
    input  logic             if_stb,
    input  logic [XLEN-1:0]  if_adr,
    output logic             if_ack,
    output logic             if_err,
    output logic             if_stall,
    output logic [XLEN-1:0]  if_dat,
    input  logic             ls_cyc,
    input  logic             ls_stb,
    input  logic             ls_we,
    input  logic [XLEN-1:0]  ls_adr,
    input  logic [XLEN-1:0]  ls_dat_w,
    input  logic [SEL_W-1:0] ls_sel,
    output logic             ls_ack,
    output logic             ls_err,
    output logic             ls_stall,
    output logic [XLEN-1:0]  ls_dat_r,
    output logic             m_cyc,
    output logic             m_stb,
    output logic             m_we,
    output logic [XLEN-1:0]  m_adr,
    output logic [XLEN-1:0]  m_dat_w,
    output logic [SEL_W-1:0] m_sel,
    input  logic             m_ack,
    input  logic             m_err,
    input  logic             m_stall,
    input  logic [XLEN-1:0]  m_dat_r
);

    arb_state_t       state;
    logic             own_if;
    logic             own_ls;
    logic             own_cyc;
    logic             own_stb;
    logic             cnt_full;
    logic             cnt_empty;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
`ifdef MR_ARB_RR_EN
    logic             last;
`endif

    assign own_if = (state == ARB_OWN_IF);
    assign own_ls = (state == ARB_OWN_LS);

    // IF fetches whole words, so its selects are all ones and it never writes.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        case (state)
            ARB_OWN_IF: begin
                own_cyc = if_cyc;
                own_stb = if_stb;
                m_adr   = if_adr;
                m_sel   = '1;
            end
            ARB_OWN_LS: begin
                own_cyc = ls_cyc;
                own_stb = ls_stb;
                m_we    = ls_we;
                m_adr   = ls_adr;
                m_dat_w = ls_dat_w;
                m_sel   = ls_sel;
            end
            default: ;
        endcase
    end

    assign m_cyc = own_cyc;
    assign m_stb = own_cyc & own_stb & ~cnt_full;

    assign if_stall = own_if ? (m_stall | cnt_full) : 1'b1;
    assign ls_stall = own_ls ? (m_stall | cnt_full) : 1'b1;

    // Responses after the owner dropped cyc belong to an aborted cycle and are swallowed.
    assign if_ack = own_if & if_cyc & m_ack;
    assign if_err = own_if & if_cyc & m_err;
    assign ls_ack = own_ls & ls_cyc & m_ack;
    assign ls_err = own_ls & ls_cyc & m_err;

    assign if_dat   = m_dat_r;
    assign ls_dat_r = m_dat_r;

    assign cnt_clr = (own_if | own_ls) & ~own_cyc;

    mr_out_cnt #(
        .MAX (MAX_OUT),
        .W   (CNT_W)
    ) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (m_stb & ~m_stall),
        .dec   (m_ack | m_err),
        .cnt   (cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
`ifdef MR_ARB_RR_EN
            last  <= ARB_M_LS;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
`ifdef MR_ARB_RR_EN
                    if (ls_cyc && (!if_cyc || last == ARB_M_IF)) begin
                        state <= ARB_OWN_LS;
                        last  <= ARB_M_LS;
                    end else if (if_cyc) begin
                        state <= ARB_OWN_IF;
                        last  <= ARB_M_IF;
                    end
`else
                    if (ls_cyc) begin
                        state <= ARB_OWN_LS;
                    end else if (if_cyc) begin
                        state <= ARB_OWN_IF;
                    end
`endif
                end
                ARB_OWN_IF: if (!if_cyc) state <= ARB_IDLE;
                ARB_OWN_LS: if (!ls_cyc) state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

    a_idle_empty: assert property (@(posedge clk) disable iff (!rst)
        (state == ARB_IDLE) |-> cnt_empty);
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
        cnt <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_mr_mem_arb.sv
// tb/tb_mr_mem_arb.sv - scoreboard bench for mr_mem_arb
module tb_mr_mem_arb;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        logic        ls;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_cyc, if_stb, if_ack, if_err, if_stall;
    logic [31:0] if_adr, if_dat;
    logic        ls_cyc, ls_stb, ls_we, ls_ack, ls_err, ls_stall;
    logic [31:0] ls_adr, ls_dat_w, ls_dat_r;
    logic [3:0]  ls_sel;
    logic        m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
    logic [31:0] m_adr, m_dat_w, m_dat_r;
    logic [3:0]  m_sel;

    int checks = 0;
    int errors = 0;
    req_t req_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    mr_mem_arb #(.MAX_OUT(2)) dut (
        .clk(clk), .rst(rst),
        .if_cyc(if_cyc), .if_stb(if_stb), .if_adr(if_adr),
        .if_ack(if_ack), .if_err(if_err), .if_stall(if_stall), .if_dat(if_dat),
        .ls_cyc(ls_cyc), .ls_stb(ls_stb), .ls_we(ls_we), .ls_adr(ls_adr),
        .ls_dat_w(ls_dat_w), .ls_sel(ls_sel),
        .ls_ack(ls_ack), .ls_err(ls_err), .ls_stall(ls_stall), .ls_dat_r(ls_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel),
        .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall), .m_dat_r(m_dat_r)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] dat);
        req_t r;
        r.adr = adr; r.we = we; r.sel = sel; r.dat = dat;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic ls, input logic err, input logic [31:0] dat);
        rsp_t r;
        r.ls = ls; r.err = err; r.dat = dat;
        rsp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted strobe and every forwarded response must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (m_stb && !m_stall) begin
                if (req_q.size() == 0) begin
                    check("unexpected_strobe", m_adr, 32'hffff_ffff);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check("req_adr", m_adr, r.adr);
                    check("req_we", {31'd0, m_we}, {31'd0, r.we});
                    check("req_sel", {28'd0, m_sel}, {28'd0, r.sel});
                    check("req_dat", m_dat_w, r.dat);
                end
            end
            if (if_ack || if_err || ls_ack || ls_err) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {28'd0, if_ack, if_err, ls_ack, ls_err}, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_flags", {28'd0, if_ack, if_err, ls_ack, ls_err},
                          {28'd0, !r.ls && !r.err, !r.ls && r.err, r.ls && !r.err, r.ls && r.err});
                    check("rsp_dat", r.ls ? ls_dat_r : if_dat, r.dat);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        if_cyc = 0; if_stb = 0; if_adr = 0;
        ls_cyc = 0; ls_stb = 0; ls_we = 0; ls_adr = 0; ls_dat_w = 0; ls_sel = 0;
        m_ack = 0; m_err = 0; m_stall = 0; m_dat_r = 0;

        @(negedge clk);
        check("rst_m_cyc", {31'd0, m_cyc}, 32'd0);
        check("rst_if_stall", {31'd0, if_stall}, 32'd1);
        check("rst_ls_stall", {31'd0, ls_stall}, 32'd1);
        check("rst_m_adr", m_adr, 32'd0);
        check("rst_m_sel", {28'd0, m_sel}, 32'd0);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_m_cyc", {31'd0, m_cyc}, 32'd0);
            check("idle_stalls", {30'd0, if_stall, ls_stall}, 32'd3);
            step();
        end

        // IF-only read
        if_cyc = 1; if_stb = 1; if_adr = 32'h8000_0000;
        push_req(32'h8000_0000, 1'b0, 4'hf, 32'd0);
        @(negedge clk); check("if_grant_lat", {31'd0, m_cyc}, 32'd0); step();
        @(negedge clk);
        check("if_m_cyc", {31'd0, m_cyc}, 32'd1);
        check("if_m_adr", m_adr, 32'h8000_0000);
        check("if_stalls", {30'd0, if_stall, ls_stall}, 32'd1);
        step();
        if_stb = 0; m_ack = 1; m_dat_r = 32'h0000_0013;
        push_rsp(1'b0, 1'b0, 32'h0000_0013);
        @(negedge clk); check("if_ls_ack", {31'd0, ls_ack}, 32'd0); step();
        m_ack = 0; if_cyc = 0;
        @(negedge clk); check("if_release", {31'd0, m_cyc}, 32'd0); step();

        // Tie: LS wins, then one dead cycle, then IF
        ls_cyc = 1; ls_stb = 1; ls_we = 1; ls_adr = 32'h1000; ls_dat_w = 32'hdead_beef; ls_sel = 4'hf;
        if_cyc = 1; if_stb = 1; if_adr = 32'h8000_0004;
        push_req(32'h1000, 1'b1, 4'hf, 32'hdead_beef);
        @(negedge clk); step();
        @(negedge clk);
        check("tie_m_we", {31'd0, m_we}, 32'd1);
        check("tie_m_adr", m_adr, 32'h1000);
        check("tie_stalls", {30'd0, if_stall, ls_stall}, 32'd2);
        step();
        ls_stb = 0; m_ack = 1; m_dat_r = 32'h0;
        push_rsp(1'b1, 1'b0, 32'h0);
        @(negedge clk); step();
        m_ack = 0; ls_cyc = 0;
        @(negedge clk);
        check("ls_abort_cyc", {31'd0, m_cyc}, 32'd0);
        check("ls_abort_if_stall", {31'd0, if_stall}, 32'd1);
        step();
        push_req(32'h8000_0004, 1'b0, 4'hf, 32'd0);
        @(negedge clk);
        check("dead_cycle", {31'd0, m_cyc}, 32'd0);
        check("dead_if_stall", {31'd0, if_stall}, 32'd1);
        step();
        @(negedge clk);
        check("if_after_ls", {31'd0, m_cyc}, 32'd1);
        check("if_after_ls_adr", m_adr, 32'h8000_0004);
        step();
        if_stb = 0; m_ack = 1; m_dat_r = 32'h0010_0073;
        push_rsp(1'b0, 1'b0, 32'h0010_0073);
        @(negedge clk); step();
        m_ack = 0; if_cyc = 0;
        @(negedge clk); step();

        // Outstanding limit, then abort at cnt=2
        if_cyc = 1; if_stb = 1; if_adr = 32'h8000_0100;
        push_req(32'h8000_0100, 1'b0, 4'hf, 32'd0);
        @(negedge clk); step();
        @(negedge clk); check("lim_stb0", {31'd0, m_stb}, 32'd1); step();
        if_adr = 32'h8000_0104; push_req(32'h8000_0104, 1'b0, 4'hf, 32'd0);
        @(negedge clk); check("lim_stb1", {31'd0, m_stb}, 32'd1); step();
        if_adr = 32'h8000_0108; push_req(32'h8000_0108, 1'b0, 4'hf, 32'd0);
        @(negedge clk);
        check("lim_full_stb", {31'd0, m_stb}, 32'd0);
        check("lim_full_stall", {31'd0, if_stall}, 32'd1);
        step();
        m_ack = 1; m_dat_r = 32'h11; push_rsp(1'b0, 1'b0, 32'h11);
        @(negedge clk); check("lim_ack_stb", {31'd0, m_stb}, 32'd0); step();
        m_ack = 0;
        @(negedge clk);
        check("lim_resume_stb", {31'd0, m_stb}, 32'd1);
        check("lim_resume_stall", {31'd0, if_stall}, 32'd0);
        step();
        if_stb = 0;
        @(negedge clk); check("lim_full_again", {31'd0, if_stall}, 32'd1); step();
        if_cyc = 0;
        @(negedge clk); check("abort_m_cyc", {31'd0, m_cyc}, 32'd0); step();
        m_ack = 1; m_dat_r = 32'hbad;
        @(negedge clk); check("late_ack", {30'd0, if_ack, ls_ack}, 32'd0); step();
        m_ack = 0; if_cyc = 1; if_stb = 1; if_adr = 32'h8000_0200;
        push_req(32'h8000_0200, 1'b0, 4'hf, 32'd0);
        @(negedge clk); step();
        @(negedge clk); check("cnt_cleared0", {31'd0, if_stall}, 32'd0); step();
        if_adr = 32'h8000_0204; push_req(32'h8000_0204, 1'b0, 4'hf, 32'd0);
        @(negedge clk); check("cnt_cleared1", {31'd0, if_stall}, 32'd0); step();
        if_stb = 0; if_cyc = 0;
        @(negedge clk); step();

        // LS read with m_stall then m_err
        ls_cyc = 1; ls_stb = 1; ls_we = 0; ls_adr = 32'h2000; ls_sel = 4'hf; ls_dat_w = 0; m_stall = 1;
        @(negedge clk); step();
        @(negedge clk); check("mstall_ls_stall", {31'd0, ls_stall}, 32'd1); step();
        m_stall = 0; push_req(32'h2000, 1'b0, 4'hf, 32'd0);
        @(negedge clk); check("mstall_release", {31'd0, ls_stall}, 32'd0); step();
        ls_stb = 0; m_err = 1; m_dat_r = 32'h0; push_rsp(1'b1, 1'b1, 32'h0);
        @(negedge clk); step();
        m_err = 0; ls_stb = 1; ls_adr = 32'h2004; push_req(32'h2004, 1'b0, 4'hf, 32'd0);
        @(negedge clk);
        check("err_one_cycle", {31'd0, ls_err}, 32'd0);
        check("err_keeps_owner", {31'd0, m_cyc}, 32'd1);
        step();
        ls_adr = 32'h2008; push_req(32'h2008, 1'b0, 4'hf, 32'd0);
        @(negedge clk); check("err_decremented", {31'd0, ls_stall}, 32'd0); step();
        ls_adr = 32'h200c;
        @(negedge clk); check("err_full", {31'd0, ls_stall}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_m_cyc", {31'd0, m_cyc}, 32'd0);
        check("arst_m_stb", {31'd0, m_stb}, 32'd0);
        check("arst_m_adr", m_adr, 32'd0);
        check("arst_stalls", {30'd0, if_stall, ls_stall}, 32'd3);
        ls_cyc = 0; ls_stb = 0;
        step(); step();
        rst = 1'b1;
        @(negedge clk); check("post_rst_m_cyc", {31'd0, m_cyc}, 32'd0);
        step();

        check("req_q_empty", req_q.size(), 32'd0);
        check("rsp_q_empty", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
